// File: rtl/run_continue_ctrl_if.sv
// Button/pause bundle between the slc3 top (master) and the
// Run/Continue conditioner (slave).
interface run_continue_ctrl_if;
    logic Run_n;
    logic Continue_n;
    logic Pause;
    logic Run_db;
    logic Continue_db;
    logic Run_go;
    logic Continue_go;
    logic Continue_pending;

    modport master (
        output Run_n,
        output Continue_n,
        output Pause,
        input  Run_db,
        input  Continue_db,
        input  Run_go,
        input  Continue_go,
        input  Continue_pending
    );

    modport slave (
        input  Run_n,
        input  Continue_n,
        input  Pause,
        output Run_db,
        output Continue_db,
        output Run_go,
        output Continue_go,
        output Continue_pending
    );
endinterface

// File: rtl/run_continue_ctrl.sv
// Run/Continue push-button conditioner: two-flop synchronizers,
// counter debouncers and a small FSM that holds an early Continue
// press until the ISDU reaches a pause state.
module run_continue_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20
) (
    input  logic               Clk,
    input  logic               Reset,
    run_continue_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_DELIVER = 2'd2;

    logic             r_run_s1;
    logic             r_run_s2;
    logic             r_cont_s1;
    logic             r_cont_s2;
    logic [CNT_W-1:0] r_run_cnt;
    logic [CNT_W-1:0] r_cont_cnt;
    logic             r_run_db;
    logic             r_cont_db;
    logic             r_run_go;
    logic             r_cont_go;
    logic             r_cont_pend;
    logic [1:0]       r_state;

    logic             w_run_s;
    logic             w_cont_s;
    logic             w_run_rise;
    logic             w_cont_rise;
    logic [1:0]       w_state_nxt;

    // Synchronized pressed levels (buttons are active-low).
    assign w_run_s  = ~r_run_s2;
    assign w_cont_s = ~r_cont_s2;

    // A press edge is the edge on which the debounced level flips 0->1;
    // flagging it here lets the pulse line up with the level change.
    assign w_run_rise  = w_run_s  & ~r_run_db  & (r_run_cnt  == CNT_LAST);
    assign w_cont_rise = w_cont_s & ~r_cont_db & (r_cont_cnt == CNT_LAST);

    // Two-flop synchronizers; reset to the released (high) level.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_run_s1  <= 1'b1;
            r_run_s2  <= 1'b1;
            r_cont_s1 <= 1'b1;
            r_cont_s2 <= 1'b1;
        end else begin
            r_run_s1  <= bus.Run_n;
            r_run_s2  <= r_run_s1;
            r_cont_s1 <= bus.Continue_n;
            r_cont_s2 <= r_cont_s1;
        end
    end

    // Run debouncer: flip only after DEBOUNCE_CYCLES consecutive disagreements.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_run_cnt <= {CNT_W{1'b0}};
            r_run_db  <= 1'b0;
        end else if (w_run_s == r_run_db) begin
            r_run_cnt <= {CNT_W{1'b0}};
        end else if (r_run_cnt == CNT_LAST) begin
            r_run_cnt <= {CNT_W{1'b0}};
            r_run_db  <= w_run_s;
        end else begin
            r_run_cnt <= r_run_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Continue debouncer, identical in behaviour to the Run one.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cont_cnt <= {CNT_W{1'b0}};
            r_cont_db  <= 1'b0;
        end else if (w_cont_s == r_cont_db) begin
            r_cont_cnt <= {CNT_W{1'b0}};
        end else if (r_cont_cnt == CNT_LAST) begin
            r_cont_cnt <= {CNT_W{1'b0}};
            r_cont_db  <= w_cont_s;
        end else begin
            r_cont_cnt <= r_cont_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Continue FSM next state; a Run press always wins and cancels Continue.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cont_rise && !w_run_rise) begin
                    w_state_nxt = bus.Pause ? ST_DELIVER : ST_PENDING;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (w_run_rise) begin
                    w_state_nxt = ST_IDLE;
                end else if (bus.Pause) begin
                    w_state_nxt = ST_DELIVER;
                end else begin
                    w_state_nxt = ST_PENDING;
                end
            end
            ST_DELIVER: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state and registered event outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_run_go    <= 1'b0;
            r_cont_go   <= 1'b0;
            r_cont_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_run_go    <= w_run_rise;
            r_cont_go   <= (w_state_nxt == ST_DELIVER);
            r_cont_pend <= (w_state_nxt == ST_PENDING);
        end
    end

    assign bus.Run_db           = r_run_db;
    assign bus.Continue_db      = r_cont_db;
    assign bus.Run_go           = r_run_go;
    assign bus.Continue_go      = r_cont_go;
    assign bus.Continue_pending = r_cont_pend;
endmodule

// File: tb/tb_run_continue_ctrl.sv
// Randomized bench for run_continue_ctrl against a window-based
// reference model of the button conditioner.
module tb_run_continue_ctrl;
    localparam int DB = 4;

    logic Clk;
    logic Reset;
    run_continue_ctrl_if u_if ();

    run_continue_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(20)) u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (u_if)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp;
    int n_err;

    // Reference state: raw samples of the last six edges (bit 0 newest).
    logic [5:0] m_run_hist;
    logic [5:0] m_cont_hist;
    logic       m_run_db;
    logic       m_cont_db;
    logic       m_run_go;
    logic       m_cont_go;
    logic       m_pend;

    task automatic check_eq(input string tag, input logic obs, input logic exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, obs, exp);
        end
    endtask

    // Advance the model by one clock edge given the inputs seen at that edge.
    task automatic model_step(input logic rst, input logic rn, input logic cn, input logic pz);
        logic run_press;
        logic cont_press;
        if (rst) begin
            m_run_hist  = 6'b111111;
            m_cont_hist = 6'b111111;
            m_run_db    = 1'b0;
            m_cont_db   = 1'b0;
            m_run_go    = 1'b0;
            m_cont_go   = 1'b0;
            m_pend      = 1'b0;
        end else begin
            m_run_hist  = {m_run_hist[4:0], rn};
            m_cont_hist = {m_cont_hist[4:0], cn};
            run_press  = 1'b0;
            cont_press = 1'b0;
            // The synced level seen at this edge is the raw level two edges
            // back; the level is accepted once four such samples agree.
            if (!m_run_db && m_run_hist[5:2] == 4'b0000) begin
                m_run_db  = 1'b1;
                run_press = 1'b1;
            end else if (m_run_db && m_run_hist[5:2] == 4'b1111) begin
                m_run_db = 1'b0;
            end
            if (!m_cont_db && m_cont_hist[5:2] == 4'b0000) begin
                m_cont_db  = 1'b1;
                cont_press = 1'b1;
            end else if (m_cont_db && m_cont_hist[5:2] == 4'b1111) begin
                m_cont_db = 1'b0;
            end
            m_run_go = run_press;
            if (m_cont_go) begin
                m_cont_go = 1'b0;
                m_pend    = 1'b0;
            end else if (run_press) begin
                m_pend    = 1'b0;
            end else if ((m_pend || cont_press) && pz) begin
                m_cont_go = 1'b1;
                m_pend    = 1'b0;
            end else if (cont_press) begin
                m_pend = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        check_eq("run_db",  u_if.Run_db,           m_run_db);
        check_eq("cont_db", u_if.Continue_db,      m_cont_db);
        check_eq("run_go",  u_if.Run_go,           m_run_go);
        check_eq("cont_go", u_if.Continue_go,      m_cont_go);
        check_eq("pending", u_if.Continue_pending, m_pend);
    endtask

    // Apply inputs, advance model and DUT one edge, then check at negedge.
    task automatic cycle(input logic rst, input logic rn, input logic cn, input logic pz);
        Reset          = rst;
        u_if.Run_n      = rn;
        u_if.Continue_n = cn;
        u_if.Pause      = pz;
        model_step(rst, rn, cn, pz);
        @(posedge Clk);
        @(negedge Clk);
        check_all();
    endtask

    function automatic int pick_len();
        if ($urandom_range(0, 2) == 0) return int'($urandom_range(1, 4));
        return int'($urandom_range(5, 24));
    endfunction

    initial begin
        logic rn;
        logic cn;
        logic pz;
        logic rst;
        int   run_left;
        int   cont_left;
        int   pause_left;
        int   rst_left;
        n_cmp = 0;
        n_err = 0;
        Reset = 1'b1;
        u_if.Run_n = 1'b1;
        u_if.Continue_n = 1'b1;
        u_if.Pause = 1'b0;
        @(negedge Clk);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);

        // Directed: clean Run press, then release.
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        // Directed: bounce shorter than the debounce window.
        for (int i = 0; i < 8; i++) cycle(1'b0, (i % 4) >= 2, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        // Directed: early Continue, then Pause releases it.
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++)  cycle(1'b0, 1'b1, 1'b1, 1'b1);
        // Directed: pending then Run cancels it.
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++)  cycle(1'b0, 1'b1, 1'b1, 1'b1);
        // Directed: reset two cycles into a debounce.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1);

        // Randomized segments of glitches, presses, pauses and resets.
        rn = 1'b1; cn = 1'b1; pz = 1'b0;
        run_left = pick_len();
        cont_left = pick_len();
        pause_left = int'($urandom_range(1, 40));
        rst_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (run_left == 0)   begin rn = ~rn; run_left = pick_len(); end
            if (cont_left == 0)  begin cn = ~cn; cont_left = pick_len(); end
            if (pause_left == 0) begin pz = ~pz; pause_left = int'($urandom_range(1, 40)); end
            if (rst_left == 0 && $urandom_range(0, 299) == 0) rst_left = int'($urandom_range(1, 2));
            rst = (rst_left != 0);
            if (rst_left != 0) rst_left--;
            cycle(rst, rn, cn, pz);
            run_left--;
            cont_left--;
            pause_left--;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
